// File: rtl/trashbin_mem_pkg.sv
// Shared types and constants for the Trashbin memory controller and its RAM.
package trashbin_mem_pkg;

   localparam int WORD_BYTES = 4;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      ACCESS,
      DONE
   } state_e;

   typedef enum logic {
      READ,
      WRITE
   } op_e;

   function automatic int index_width(input int words);
      return $clog2(words);
   endfunction

endpackage

// File: rtl/trashbin_sram.sv
// Single-port synchronous word RAM with one-cycle read latency, block-RAM inferable.
module trashbin_sram
   import trashbin_mem_pkg::*;
#(
   parameter int WORDS = 1024,
   parameter int AW    = 10
) (
   input  logic                      clk,
   input  logic                      en,
   input  logic                      we,
   input  logic [AW-1:0]             addr,
   input  logic [8*WORD_BYTES-1:0]   wdata,
   output logic [8*WORD_BYTES-1:0]   rdata
);

   logic [8*WORD_BYTES-1:0] mem [WORDS];

   always_ff @(posedge clk) begin
      if (en) begin
         if (we) begin
            mem[addr] <= wdata;
         end else begin
            rdata <= mem[addr];
         end
      end
   end

endmodule

// File: rtl/trashbin_memory_controller.sv
// Wait-stated RAM controller for the Trashbin core with a four-phase ReadOK/WriteOK handshake.
// Define TRASHBIN_MEM_FAULT_CHECK_EN to flag misaligned or out-of-range addresses via BusFault.
module trashbin_memory_controller
   import trashbin_mem_pkg::*;
#(
   parameter int MEM_WORDS   = 1024,
   parameter int WAIT_STATES = 2
) (
   input  logic        CoreClock,
   input  logic        CoreReset,
   input  logic [31:0] AddressBus,
   input  logic [31:0] DataWriteBus,
   input  logic        ReadAssert,
   input  logic        WriteAssert,
   output logic [31:0] DataReadBus,
   output logic        ReadOK,
   output logic        WriteOK,
   output logic        BusFault
);

   localparam int IDX_W = index_width(MEM_WORDS);
   localparam int LSB   = $clog2(WORD_BYTES);
   localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

   state_e           state;
   op_e              op;
   logic [3:0]       count;
   logic [IDX_W-1:0] index;
   logic [31:0]      wdata;
   logic             fault;
   logic             addr_fault;
   logic [IDX_W-1:0] bus_index;
   logic [IDX_W-1:0] ram_addr;
   logic [31:0]      ram_rdata;
   logic             request;
   logic             rd_issue;
   logic             wr_issue;

   assign bus_index = AddressBus[IDX_W+LSB-1:LSB];

`ifdef TRASHBIN_MEM_FAULT_CHECK_EN
   assign addr_fault = (AddressBus[LSB-1:0] != '0) || ((AddressBus >> (IDX_W + LSB)) != 32'd0);
`else
   logic unused_addr;
   assign unused_addr = ^{AddressBus[31:IDX_W+LSB], AddressBus[LSB-1:0]};
   assign addr_fault  = 1'b0;
`endif

   assign request = (op == WRITE) ? WriteAssert : ReadAssert;

   // Reads are launched on the edge entering ACCESS so the data is ready to register when ACCESS ends.
   assign rd_issue = ((WAIT_STATES == 0) && (state == IDLE) && ReadAssert && !WriteAssert) ||
                     ((state == WAIT) && (count == 4'd1) && (op == READ));
   assign wr_issue = (state == ACCESS) && (op == WRITE) && !fault && !CoreReset;
   assign ram_addr = (state == IDLE) ? bus_index : index;

   trashbin_sram #(
      .WORDS (MEM_WORDS),
      .AW    (IDX_W)
   ) u_sram (
      .clk   (CoreClock),
      .en    (rd_issue || wr_issue),
      .we    (wr_issue),
      .addr  (ram_addr),
      .wdata (wdata),
      .rdata (ram_rdata)
   );

   always_ff @(posedge CoreClock) begin
      if (CoreReset) begin
         state       <= IDLE;
         op          <= READ;
         count       <= 4'd0;
         index       <= '0;
         wdata       <= 32'd0;
         fault       <= 1'b0;
         DataReadBus <= 32'd0;
         ReadOK      <= 1'b0;
         WriteOK     <= 1'b0;
         BusFault    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (WriteAssert || ReadAssert) begin
                  op    <= WriteAssert ? WRITE : READ;
                  index <= bus_index;
                  wdata <= DataWriteBus;
                  fault <= addr_fault;
                  count <= WAIT_INIT;
                  state <= (WAIT_STATES == 0) ? ACCESS : WAIT;
               end
            end
            WAIT: begin
               count <= count - 4'd1;
               if (count == 4'd1) begin
                  state <= ACCESS;
               end
            end
            ACCESS: begin
               state    <= DONE;
               BusFault <= fault;
               if (op == WRITE) begin
                  WriteOK <= 1'b1;
               end else begin
                  ReadOK <= 1'b1;
                  if (!fault) begin
                     DataReadBus <= ram_rdata;
                  end
               end
            end
            DONE: begin
               if (!request) begin
                  state    <= IDLE;
                  ReadOK   <= 1'b0;
                  WriteOK  <= 1'b0;
                  BusFault <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_trashbin_memory_controller.sv
// Self-checking bench for trashbin_memory_controller: transaction-level reference model,
// per-cycle output comparison, directed scenarios and randomized traffic.
module tb_trashbin_memory_controller;

   localparam int MW    = 1024;
   localparam int WS    = 2;
   localparam int IDX_W = $clog2(MW);
   localparam int LAT   = WS + 2;

   logic        CoreClock    = 1'b0;
   logic        CoreReset    = 1'b1;
   logic [31:0] AddressBus   = 32'd0;
   logic [31:0] DataWriteBus = 32'd0;
   logic        ReadAssert   = 1'b0;
   logic        WriteAssert  = 1'b0;
   logic [31:0] DataReadBus;
   logic        ReadOK;
   logic        WriteOK;
   logic        BusFault;

   int checks = 0;
   int errors = 0;

   trashbin_memory_controller #(
      .MEM_WORDS   (MW),
      .WAIT_STATES (WS)
   ) dut (
      .CoreClock    (CoreClock),
      .CoreReset    (CoreReset),
      .AddressBus   (AddressBus),
      .DataWriteBus (DataWriteBus),
      .ReadAssert   (ReadAssert),
      .WriteAssert  (WriteAssert),
      .DataReadBus  (DataReadBus),
      .ReadOK       (ReadOK),
      .WriteOK      (WriteOK),
      .BusFault     (BusFault)
   );

   always #5 CoreClock = ~CoreClock;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: actual %h, required %h at %0t", name, actual, expected, $time);
      end
   endtask

   function automatic bit addrFaults(input logic [31:0] a);
`ifdef TRASHBIN_MEM_FAULT_CHECK_EN
      return (a[1:0] != 2'b00) || (a[31:IDX_W+2] != '0);
`else
      return 1'b0;
`endif
   endfunction

   // Reference model: a transaction is accepted when idle, completes WS+1 edges later,
   // and retires on the first edge its request is seen low.
   logic [31:0]      model_mem [MW];
   bit               busy = 0;
   bit               model_done = 0;
   bit               m_write = 0;
   bit               m_fault = 0;
   logic [IDX_W-1:0] m_idx = '0;
   logic [31:0]      m_data = 32'd0;
   int               cyc = 0;
   int               done_at = 0;
   logic [31:0]      exp_data = 32'd0;
   bit               exp_rok = 0;
   bit               exp_wok = 0;
   bit               exp_fault = 0;

   always @(posedge CoreClock) begin
      cyc++;
      if (CoreReset) begin
         busy = 0; model_done = 0;
         exp_data = 32'd0; exp_rok = 0; exp_wok = 0; exp_fault = 0;
      end else if (!busy) begin
         if (WriteAssert || ReadAssert) begin
            busy = 1; model_done = 0;
            m_write = WriteAssert;
            m_idx   = AddressBus[IDX_W+1:2];
            m_data  = DataWriteBus;
            m_fault = addrFaults(AddressBus);
            done_at = cyc + WS + 1;
         end
      end else if (!model_done) begin
         if (cyc == done_at) begin
            model_done = 1;
            exp_fault  = m_fault;
            if (m_write) begin
               exp_wok = 1;
               if (!m_fault) model_mem[m_idx] = m_data;
            end else begin
               exp_rok = 1;
               if (!m_fault) exp_data = model_mem[m_idx];
            end
         end
      end else if (!(m_write ? WriteAssert : ReadAssert)) begin
         busy = 0; model_done = 0;
         exp_rok = 0; exp_wok = 0; exp_fault = 0;
      end
   end

   bit compare_en = 0;

   always @(negedge CoreClock) begin
      if (compare_en) begin
         checkOutput("DataReadBus", DataReadBus, exp_data);
         checkOutput("ReadOK", 32'(ReadOK), 32'(exp_rok));
         checkOutput("WriteOK", 32'(WriteOK), 32'(exp_wok));
         checkOutput("BusFault", 32'(BusFault), 32'(exp_fault));
         checkOutput("ok_exclusive", 32'(ReadOK & WriteOK), 32'd0);
      end
   end

   task automatic applyStimulus(input logic rd, input logic wr, input logic [31:0] addr, input logic [31:0] data);
      @(negedge CoreClock);
      ReadAssert   = rd;
      WriteAssert  = wr;
      AddressBus   = addr;
      DataWriteBus = data;
   endtask

   // Raise a request, wait (bounded) for its OK, hold it 'hold' more cycles, then drop it.
   task automatic runTransaction(input logic rd, input logic wr, input logic [31:0] addr,
                                 input logic [31:0] data, input int hold, output int lat);
      applyStimulus(rd, wr, addr, data);
      lat = 0;
      while (!(ReadOK || WriteOK) && lat < 40) begin
         @(negedge CoreClock);
         lat++;
      end
      checkOutput("ok_seen", 32'(ReadOK || WriteOK), 32'd1);
      repeat (hold) @(negedge CoreClock);
      ReadAssert  = 1'b0;
      WriteAssert = 1'b0;
   endtask

   task automatic randomTransaction();
      logic        rd, wr;
      logic [31:0] addr;
      int          mode, lat;
      wr   = 1'($urandom_range(0, 1));
      rd   = !wr || ($urandom_range(0, 3) == 0);
      addr = {20'h0, 6'h0, 4'($urandom_range(0, 15)), 2'b00};
      if ($urandom_range(0, 7) == 0) addr[31:12] = 20'($urandom);
      if ($urandom_range(0, 7) == 0) addr[1:0] = 2'($urandom_range(1, 3));
      mode = $urandom_range(0, 9);
      repeat ($urandom_range(0, 2)) @(negedge CoreClock);
      if (mode < 5) begin
         runTransaction(rd, wr, addr, $urandom, 0, lat);
      end else if (mode < 7) begin
         runTransaction(rd, wr, addr, $urandom, $urandom_range(1, 3), lat);
      end else if (mode < 9) begin
         applyStimulus(rd, wr, addr, $urandom);
         @(negedge CoreClock);
         ReadAssert  = 1'b0;
         WriteAssert = 1'b0;
         lat = 0;
         while (!(ReadOK || WriteOK) && lat < 40) begin
            @(negedge CoreClock);
            lat++;
         end
         checkOutput("early_ok_seen", 32'(ReadOK || WriteOK), 32'd1);
      end else begin
         applyStimulus(rd, wr, addr, $urandom);
         repeat ($urandom_range(0, LAT + 2)) @(negedge CoreClock);
         CoreReset   = 1'b1;
         ReadAssert  = 1'b0;
         WriteAssert = 1'b0;
         @(negedge CoreClock);
         CoreReset = 1'b0;
      end
   endtask

   initial begin
      int lat;
      int first_hi;
      int hi_count;

      repeat (3) @(negedge CoreClock);
      compare_en = 1;
      CoreReset  = 1'b0;

      for (int i = 0; i < 10; i++) begin
         @(negedge CoreClock);
         checkOutput("idle_ReadOK", 32'(ReadOK), 32'd0);
         checkOutput("idle_WriteOK", 32'(WriteOK), 32'd0);
         checkOutput("idle_BusFault", 32'(BusFault), 32'd0);
         checkOutput("idle_DataReadBus", DataReadBus, 32'd0);
      end

      runTransaction(1'b0, 1'b1, 32'h10, 32'h1234_5678, 0, lat);
      checkOutput("write_latency", 32'(lat), 32'd4);
      runTransaction(1'b1, 1'b0, 32'h10, 32'd0, 0, lat);
      checkOutput("read_latency", 32'(lat), 32'd4);
      checkOutput("read_data", DataReadBus, 32'h1234_5678);

      runTransaction(1'b1, 1'b1, 32'h20, 32'hA5A5_A5A5, 0, lat);
      checkOutput("simul_WriteOK", 32'(WriteOK), 32'd1);
      checkOutput("simul_ReadOK", 32'(ReadOK), 32'd0);
      runTransaction(1'b1, 1'b0, 32'h20, 32'd0, 0, lat);
      checkOutput("simul_readback", DataReadBus, 32'hA5A5_A5A5);

      runTransaction(1'b0, 1'b1, 32'h30, 32'h1111_1111, 0, lat);
      applyStimulus(1'b0, 1'b1, 32'h30, 32'hDEAD_BEEF);
      @(negedge CoreClock);
      CoreReset   = 1'b1;
      WriteAssert = 1'b0;
      @(negedge CoreClock);
      CoreReset = 1'b0;
      checkOutput("rst_WriteOK", 32'(WriteOK), 32'd0);
      checkOutput("rst_DataReadBus", DataReadBus, 32'd0);
      runTransaction(1'b1, 1'b0, 32'h30, 32'd0, 0, lat);
      checkOutput("rst_write_discarded", DataReadBus, 32'h1111_1111);

      applyStimulus(1'b1, 1'b0, 32'h10, 32'd0);
      @(negedge CoreClock);
      ReadAssert = 1'b0;
      first_hi = -1;
      hi_count = 0;
      for (int i = 2; i <= 10; i++) begin
         @(negedge CoreClock);
         if (ReadOK) begin
            hi_count++;
            if (first_hi < 0) first_hi = i;
         end
      end
      checkOutput("early_ok_cycles", 32'(hi_count), 32'd1);
      checkOutput("early_ok_position", 32'(first_hi), 32'd4);
      checkOutput("early_data", DataReadBus, 32'h1234_5678);
      runTransaction(1'b1, 1'b0, 32'h20, 32'd0, 0, lat);
      checkOutput("after_early_latency", 32'(lat), 32'd4);

      runTransaction(1'b0, 1'b1, 32'h0, 32'h0BAD_F00D, 0, lat);
      runTransaction(1'b1, 1'b0, 32'h10, 32'd0, 0, lat);
`ifdef TRASHBIN_MEM_FAULT_CHECK_EN
      runTransaction(1'b1, 1'b0, 32'h2, 32'd0, 0, lat);
      checkOutput("fault_read_BusFault", 32'(BusFault), 32'd1);
      checkOutput("fault_read_ReadOK", 32'(ReadOK), 32'd1);
      checkOutput("fault_read_data_kept", DataReadBus, 32'h1234_5678);
      runTransaction(1'b0, 1'b1, 32'hFFFF_0000, 32'hCAFE_F00D, 0, lat);
      checkOutput("fault_write_BusFault", 32'(BusFault), 32'd1);
      checkOutput("fault_write_WriteOK", 32'(WriteOK), 32'd1);
      checkOutput("fault_write_data_kept", DataReadBus, 32'h1234_5678);
      runTransaction(1'b1, 1'b0, 32'h0, 32'd0, 0, lat);
      checkOutput("fault_ram_unchanged", DataReadBus, 32'h0BAD_F00D);
      checkOutput("fault_clean_BusFault", 32'(BusFault), 32'd0);
`else
      runTransaction(1'b1, 1'b0, 32'h2, 32'd0, 0, lat);
      checkOutput("unaligned_reads_word0", DataReadBus, 32'h0BAD_F00D);
      checkOutput("unaligned_BusFault", 32'(BusFault), 32'd0);
`endif

      for (int w = 0; w < 16; w++) begin
         runTransaction(1'b0, 1'b1, 32'(w * 4), $urandom, 0, lat);
      end
      for (int n = 0; n < 300; n++) begin
         randomTransaction();
      end
      repeat (4) @(negedge CoreClock);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: simulation still running at %0t", $time);
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
